// File: rtl/filter_gpu_pkg.sv
// Shared types and helpers for the filter GPU load/store path.
package filter_gpu_pkg;

  localparam int DEF_DATA_W = 18;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lsu_state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/lane_addr_gen.sv
// Per-port strided address generation for one beat of a vector access.
module lane_addr_gen
  import filter_gpu_pkg::*;
#(
  parameter int LANES  = 3,
  parameter int PORTS  = 3,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BEAT_W = 1
) (
  input  logic [ADDR_W-1:0]            base,
  input  logic [ADDR_W-1:0]            stride,
  input  logic [BEAT_W-1:0]            beat,
  output logic [PORTS-1:0][ADDR_W-1:0] addr,
  output logic [PORTS-1:0]             lane_ok
);

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [31:0] lane;
    assign lane       = 32'(beat) * 32'(PORTS) + 32'(p);
    assign lane_ok[p] = (lane < 32'(LANES));
    // Only the low ADDR_W bits of the lane index matter once wrapped.
    assign addr[p]    = base + lane[ADDR_W-1:0] * stride;
  end

endmodule

// File: rtl/vec_lsu.sv
// Vector load/store unit: LANES lanes serialised over PORTS memory ports.
//   state | meaning
//   IDLE  | ready for a request
//   ISSUE | one beat per cycle drives the memory ports
//   WAIT  | last load beat's data returns and is captured
//   RESP  | one-cycle completion pulse
module vec_lsu
  import filter_gpu_pkg::*;
#(
  parameter int LANES  = 3,
  parameter int PORTS  = 3,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_base,
  input  logic [ADDR_W-1:0]            req_stride,
  input  logic [LANES-1:0]             req_mask,
  input  logic [LANES-1:0][DATA_W-1:0] req_wdata,
  output logic [PORTS-1:0]             mem_en,
  output logic                         mem_we,
  output logic [PORTS-1:0][ADDR_W-1:0] mem_addr,
  output logic [PORTS-1:0][DATA_W-1:0] mem_wdata,
  input  logic [PORTS-1:0][DATA_W-1:0] mem_rdata,
  output logic                         resp_valid,
  output logic [LANES-1:0][DATA_W-1:0] resp_rdata,
  output logic                         stall
);

  localparam int BEATS  = ceil_div(LANES, PORTS);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  lsu_state_t                   state_q, state_d;
  logic [BEAT_W-1:0]            beat_q, cap_beat_q;
  logic                         write_q;
  logic [ADDR_W-1:0]            base_q, stride_q;
  logic [LANES-1:0]             mask_q;
  logic [LANES-1:0][DATA_W-1:0] wdata_q, rdata_q;
  logic [PORTS-1:0]             cap_en_q;
  logic [PORTS-1:0][ADDR_W-1:0] gen_addr;
  logic [PORTS-1:0]             gen_ok;
  logic                         accept;

  assign accept = req_valid && (state_q == IDLE);

  lane_addr_gen #(
    .LANES (LANES),
    .PORTS (PORTS),
    .ADDR_W(ADDR_W),
    .BEAT_W(BEAT_W)
  ) u_addr_gen (
    .base   (base_q),
    .stride (stride_q),
    .beat   (beat_q),
    .addr   (gen_addr),
    .lane_ok(gen_ok)
  );

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ISSUE;
      ISSUE:   if (beat_q == LAST_BEAT) state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    stall      = (state_q != IDLE);
    resp_valid = (state_q == RESP);
    mem_we     = (state_q == ISSUE) ? write_q : 1'b0;
    mem_en     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q == ISSUE) begin
      for (int p = 0; p < PORTS; p++) begin
        for (int l = 0; l < LANES; l++) begin
          if (gen_ok[p] && mask_q[l] && (l == int'(beat_q) * PORTS + p)) begin
            mem_en[p]    = 1'b1;
            mem_addr[p]  = gen_addr[p];
            mem_wdata[p] = wdata_q[l];
          end
        end
      end
    end
  end

  // Load data lands one cycle after its beat, so capture lags by one beat.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      beat_q     <= '0;
      cap_beat_q <= '0;
      cap_en_q   <= '0;
      write_q    <= 1'b0;
      base_q     <= '0;
      stride_q   <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      cap_en_q   <= (state_q == ISSUE && !write_q) ? mem_en : '0;
      cap_beat_q <= beat_q;
      if (state_q == ISSUE) beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
      if (accept) begin
        beat_q   <= '0;
        write_q  <= req_write;
        base_q   <= req_base;
        stride_q <= req_stride;
        mask_q   <= req_mask;
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
      end else begin
        for (int p = 0; p < PORTS; p++) begin
          for (int l = 0; l < LANES; l++) begin
            if (cap_en_q[p] && (l == int'(cap_beat_q) * PORTS + p)) rdata_q[l] <= mem_rdata[p];
          end
        end
      end
    end
  end

  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_vec_lsu.sv
// Self-checking bench: a 3x3 instance and an 8-lane/3-port instance with behavioural memories.
module tb_vec_lsu;
  localparam int AW = 10;
  localparam int DW = 18;
  localparam int BL = 8;
  localparam int P  = 3;

  typedef logic [2:0][DW-1:0]    vec_a_t;
  typedef logic [BL-1:0][DW-1:0] vec_b_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  logic                a_rst, a_valid, a_ready, a_write, a_we, a_resp, a_stall;
  logic [AW-1:0]       a_base, a_stride;
  logic [2:0]          a_mask;
  vec_a_t              a_wdata, a_rdata;
  logic [P-1:0]        a_en;
  logic [P-1:0][AW-1:0] a_addr;
  logic [P-1:0][DW-1:0] a_mwdata, a_mrdata;

  logic                b_rst, b_valid, b_ready, b_write, b_we, b_resp, b_stall;
  logic [AW-1:0]       b_base, b_stride;
  logic [BL-1:0]       b_mask;
  vec_b_t              b_wdata, b_rdata;
  logic [P-1:0]        b_en;
  logic [P-1:0][AW-1:0] b_addr;
  logic [P-1:0][DW-1:0] b_mwdata, b_mrdata;

  vec_a_t exp_a[$];
  vec_b_t exp_b[$];

  logic [DW-1:0] mem_b [1024];
  logic          mem_init;

  vec_lsu #(.LANES(3), .PORTS(P), .DATA_W(DW), .ADDR_W(AW)) u_dut_a (
    .CLK(CLK), .RST(a_rst), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_base(a_base), .req_stride(a_stride), .req_mask(a_mask), .req_wdata(a_wdata),
    .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_mwdata), .mem_rdata(a_mrdata),
    .resp_valid(a_resp), .resp_rdata(a_rdata), .stall(a_stall));

  vec_lsu #(.LANES(BL), .PORTS(P), .DATA_W(DW), .ADDR_W(AW)) u_dut_b (
    .CLK(CLK), .RST(b_rst), .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_base(b_base), .req_stride(b_stride), .req_mask(b_mask), .req_wdata(b_wdata),
    .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_mwdata), .mem_rdata(b_mrdata),
    .resp_valid(b_resp), .resp_rdata(b_rdata), .stall(b_stall));

  // Memory A is load-only and holds data == address.
  always @(posedge CLK) begin
    for (int p = 0; p < P; p++) if (a_en[p]) a_mrdata[p] <= DW'(a_addr[p]);
  end

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem_b[i] <= DW'(i);
    end else begin
      for (int p = 0; p < P; p++) begin
        if (b_en[p]) begin
          if (b_we) mem_b[b_addr[p]] <= b_mwdata[p];
          b_mrdata[p] <= mem_b[b_addr[p]];
        end
      end
    end
  end

  function automatic vec_a_t exp_load_a(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                                        input logic [2:0] mask);
    logic [AW-1:0] ad;
    exp_load_a = '0;
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        ad = base + AW'(i) * stride;
        exp_load_a[i] = DW'(ad);
      end
    end
  endfunction

  task automatic send_a(input logic wr, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                        input logic [2:0] mask, input vec_a_t wd);
    a_write = wr; a_base = base; a_stride = stride; a_mask = mask; a_wdata = wd; a_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    a_valid = 1'b0; a_base = ~base; a_stride = ~stride; a_mask = ~mask; a_write = ~wr;
    a_wdata = {3{DW'($urandom)}};
  endtask

  task automatic send_b(input logic wr, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                        input logic [BL-1:0] mask, input vec_b_t wd);
    b_write = wr; b_base = base; b_stride = stride; b_mask = mask; b_wdata = wd; b_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    b_valid = 1'b0; b_base = ~base; b_stride = ~stride; b_mask = ~mask; b_write = ~wr;
    b_wdata = {BL{DW'($urandom)}};
  endtask

  task automatic wait_resp_a(input int start, output int at);
    at = start;
    while (a_resp !== 1'b1 && at < start + 30) begin
      @(negedge CLK);
      at++;
    end
  endtask

  task automatic wait_resp_b(input int start, output int at);
    at = start;
    while (b_resp !== 1'b1 && at < start + 30) begin
      @(negedge CLK);
      at++;
    end
  endtask

  task automatic test_reset();
    a_rst = 1'b0; b_rst = 1'b0; mem_init = 1'b1;
    a_valid = 1'b0; a_write = 1'b0; a_base = '0; a_stride = '0; a_mask = '0; a_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_base = '0; b_stride = '0; b_mask = '0; b_wdata = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    total++;
    if ({a_ready, a_stall, a_resp, a_en, a_we} !== 7'b1000000)
      $display("FAIL reset_ctrl_a got %b want 1000000", {a_ready, a_stall, a_resp, a_en, a_we});
    else passed++;
    total++;
    if (a_addr !== '0 || a_mwdata !== '0 || a_rdata !== '0)
      $display("FAIL reset_data_a got addr=%h wdata=%h rdata=%h want all 0", a_addr, a_mwdata, a_rdata);
    else passed++;
    total++;
    if ({b_ready, b_stall, b_resp, b_en, b_we} !== 7'b1000000 || b_addr !== '0 || b_rdata !== '0)
      $display("FAIL reset_b got ctrl=%b addr=%h rdata=%h want 1000000/0/0",
               {b_ready, b_stall, b_resp, b_en, b_we}, b_addr, b_rdata);
    else passed++;
    a_rst = 1'b1; b_rst = 1'b1; mem_init = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic_load();
    int at;
    vec_a_t e;
    exp_a.push_back(exp_load_a(10'd10, 10'd1, 3'b111));
    send_a(1'b0, 10'd10, 10'd1, 3'b111, '0);
    total++;
    if (a_en !== 3'b111 || a_we !== 1'b0 || a_addr !== {10'd12, 10'd11, 10'd10})
      $display("FAIL basic_issue got en=%b we=%b addr=%h want 111/0/{12,11,10}", a_en, a_we, a_addr);
    else passed++;
    total++;
    if (a_ready !== 1'b0 || a_stall !== 1'b1)
      $display("FAIL basic_busy got ready=%b stall=%b want 0/1", a_ready, a_stall);
    else passed++;
    @(negedge CLK);
    total++;
    if (a_en !== 3'b000 || a_stall !== 1'b1 || a_resp !== 1'b0)
      $display("FAIL basic_wait got en=%b stall=%b resp=%b want 000/1/0", a_en, a_stall, a_resp);
    else passed++;
    wait_resp_a(2, at);
    total++;
    if (at !== 3) $display("FAIL basic_latency got cycle %0d want 3", at);
    else passed++;
    if (a_resp === 1'b1 && exp_a.size() > 0) begin
      e = exp_a.pop_front();
      total++;
      if (a_rdata !== e || a_stall !== 1'b1) $display("FAIL basic_rdata got %h stall=%b want %h/1", a_rdata, a_stall, e);
      else passed++;
    end
    @(negedge CLK);
    total++;
    if (a_resp !== 1'b0 || a_ready !== 1'b1 || a_stall !== 1'b0 || a_rdata !== e)
      $display("FAIL basic_after got resp=%b ready=%b stall=%b rdata=%h want 0/1/0/%h", a_resp, a_ready, a_stall, a_rdata, e);
    else passed++;
  endtask

  task automatic test_mask();
    int at;
    vec_a_t e;
    exp_a.push_back(exp_load_a(10'd20, 10'd2, 3'b101));
    send_a(1'b0, 10'd20, 10'd2, 3'b101, {18'd3, 18'd2, 18'd1});
    total++;
    if (a_en !== 3'b101 || a_addr !== {10'd24, 10'd0, 10'd20} || a_mwdata !== {18'd3, 18'd0, 18'd1})
      $display("FAIL mask_issue got en=%b addr=%h wdata=%h want 101/{24,0,20}/{3,0,1}", a_en, a_addr, a_mwdata);
    else passed++;
    total++;
    if (a_rdata !== '0) $display("FAIL mask_clear got %h want 0", a_rdata);
    else passed++;
    wait_resp_a(1, at);
    total++;
    if (at !== 3) $display("FAIL mask_latency got cycle %0d want 3", at);
    else passed++;
    if (a_resp === 1'b1 && exp_a.size() > 0) begin
      e = exp_a.pop_front();
      total++;
      if (a_rdata !== e) $display("FAIL mask_rdata got %h want %h", a_rdata, e);
      else passed++;
    end
    @(negedge CLK);
  endtask

  task automatic test_stride_zero();
    int at;
    vec_a_t e;
    exp_a.push_back(exp_load_a(10'd7, 10'd0, 3'b111));
    send_a(1'b0, 10'd7, 10'd0, 3'b111, '0);
    total++;
    if (a_en !== 3'b111 || a_addr !== {10'd7, 10'd7, 10'd7})
      $display("FAIL stride0_addr got en=%b addr=%h want 111/{7,7,7}", a_en, a_addr);
    else passed++;
    wait_resp_a(1, at);
    total++;
    if (at !== 3) $display("FAIL stride0_latency got cycle %0d want 3", at);
    else passed++;
    if (a_resp === 1'b1 && exp_a.size() > 0) begin
      e = exp_a.pop_front();
      total++;
      if (a_rdata !== e) $display("FAIL stride0_rdata got %h want %h", a_rdata, e);
      else passed++;
    end
    @(negedge CLK);
  endtask

  task automatic test_zero_mask();
    int at;
    vec_a_t e;
    exp_a.push_back('0);
    send_a(1'b0, 10'd50, 10'd5, 3'b000, '0);
    total++;
    if (a_en !== 3'b000 || a_addr !== '0 || a_stall !== 1'b1)
      $display("FAIL zmask_issue got en=%b addr=%h stall=%b want 000/0/1", a_en, a_addr, a_stall);
    else passed++;
    wait_resp_a(1, at);
    total++;
    if (at !== 3) $display("FAIL zmask_latency got cycle %0d want 3", at);
    else passed++;
    if (a_resp === 1'b1 && exp_a.size() > 0) begin
      e = exp_a.pop_front();
      total++;
      if (a_rdata !== e) $display("FAIL zmask_rdata got %h want %h", a_rdata, e);
      else passed++;
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int last_acc, n_acc, got;
    vec_a_t e;
    last_acc = -1; n_acc = 0; got = 0;
    a_write = 1'b0; a_stride = 10'd1; a_mask = 3'b111; a_wdata = '0;
    for (int c = 0; c < 20; c++) begin
      if (a_resp === 1'b1) begin
        got++;
        total++;
        if (exp_a.size() == 0) $display("FAIL b2b_unexpected got resp at cycle %0d want none", c);
        else begin
          e = exp_a.pop_front();
          if (a_rdata !== e) $display("FAIL b2b_rdata got %h want %h", a_rdata, e);
          else passed++;
        end
      end
      a_base  = AW'(100 + 7 * c);
      a_valid = (c < 13);
      if (a_ready === 1'b1 && a_valid) begin
        exp_a.push_back(exp_load_a(a_base, 10'd1, 3'b111));
        if (last_acc >= 0) begin
          total++;
          if (c - last_acc !== 4) $display("FAIL b2b_period got %0d want 4", c - last_acc);
          else passed++;
        end
        last_acc = c;
        n_acc++;
      end
      @(negedge CLK);
    end
    a_valid = 1'b0;
    total++;
    if (n_acc !== 4 || got !== 4 || exp_a.size() !== 0)
      $display("FAIL b2b_count got acc=%0d resp=%0d left=%0d want 4/4/0", n_acc, got, exp_a.size());
    else passed++;
  endtask

  task automatic test_store_multibeat();
    int at;
    vec_b_t wd, e;
    for (int i = 0; i < BL; i++) wd[i] = DW'(100 + i);
    exp_b.push_back('0);
    send_b(1'b1, 10'd1020, 10'd3, 8'hFF, wd);
    total++;
    if (b_en !== 3'b111 || b_we !== 1'b1 || b_addr !== {10'd2, 10'd1023, 10'd1020} ||
        b_mwdata !== {18'd102, 18'd101, 18'd100})
      $display("FAIL st_beat0 got en=%b we=%b addr=%h wdata=%h", b_en, b_we, b_addr, b_mwdata);
    else passed++;
    @(negedge CLK);
    total++;
    if (b_en !== 3'b111 || b_we !== 1'b1 || b_addr !== {10'd11, 10'd8, 10'd5})
      $display("FAIL st_beat1 got en=%b we=%b addr=%h want 111/1/{11,8,5}", b_en, b_we, b_addr);
    else passed++;
    @(negedge CLK);
    total++;
    if (b_en !== 3'b011 || b_we !== 1'b1 || b_addr !== {10'd0, 10'd17, 10'd14} ||
        b_mwdata !== {18'd0, 18'd107, 18'd106})
      $display("FAIL st_beat2 got en=%b we=%b addr=%h wdata=%h", b_en, b_we, b_addr, b_mwdata);
    else passed++;
    @(negedge CLK);
    total++;
    if (b_en !== 3'b000 || b_we !== 1'b0 || b_stall !== 1'b1)
      $display("FAIL st_wait got en=%b we=%b stall=%b want 000/0/1", b_en, b_we, b_stall);
    else passed++;
    wait_resp_b(4, at);
    total++;
    if (at !== 5) $display("FAIL st_latency got cycle %0d want 5", at);
    else passed++;
    if (b_resp === 1'b1 && exp_b.size() > 0) begin
      e = exp_b.pop_front();
      total++;
      if (b_rdata !== e) $display("FAIL st_rdata got %h want %h", b_rdata, e);
      else passed++;
    end
    @(negedge CLK);
    total++;
    if (mem_b[1020] !== 18'd100 || mem_b[1023] !== 18'd101 || mem_b[2] !== 18'd102 ||
        mem_b[11] !== 18'd105 || mem_b[17] !== 18'd107)
      $display("FAIL st_memory got %0d %0d %0d %0d %0d want 100 101 102 105 107",
               mem_b[1020], mem_b[1023], mem_b[2], mem_b[11], mem_b[17]);
    else passed++;
  endtask

  task automatic test_reset_mid_op();
    int at;
    logic seen;
    vec_b_t e;
    send_b(1'b0, 10'd40, 10'd1, 8'hFF, '0);
    @(negedge CLK);
    total++;
    if (b_en !== 3'b111 || b_addr !== {10'd45, 10'd44, 10'd43})
      $display("FAIL rst_beat1 got en=%b addr=%h want 111/{45,44,43}", b_en, b_addr);
    else passed++;
    b_rst = 1'b0;
    @(negedge CLK);
    total++;
    if ({b_ready, b_stall, b_resp, b_en, b_we} !== 7'b1000000 || b_addr !== '0 ||
        b_mwdata !== '0 || b_rdata !== '0)
      $display("FAIL rst_midop got ctrl=%b addr=%h rdata=%h want 1000000/0/0",
               {b_ready, b_stall, b_resp, b_en, b_we}, b_addr, b_rdata);
    else passed++;
    b_rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      if (b_resp === 1'b1) seen = 1'b1;
      @(negedge CLK);
    end
    total++;
    if (seen !== 1'b0) $display("FAIL rst_no_resp got resp=1 want 0");
    else passed++;
    e = '0;
    for (int i = 0; i < 4; i++) e[i] = DW'(40 + i);
    exp_b.push_back(e);
    send_b(1'b0, 10'd40, 10'd1, 8'h0F, '0);
    wait_resp_b(1, at);
    total++;
    if (at !== 5) $display("FAIL rst_relaunch_latency got cycle %0d want 5", at);
    else passed++;
    if (b_resp === 1'b1 && exp_b.size() > 0) begin
      e = exp_b.pop_front();
      total++;
      if (b_rdata !== e) $display("FAIL rst_relaunch_rdata got %h want %h", b_rdata, e);
      else passed++;
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_mask();
    test_stride_zero();
    test_zero_mask();
    test_back_to_back();
    test_store_multibeat();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
